// File: rtl/uart_frame_pkg.sv
// Shared types for the UART host-frame decoder: FSM states, status codes and the default sync marker.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CHK     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_decoder.sv
// Parses SYNC, LEN, payload[, CHK] host frames from a byte stream into WORD_W-bit words with per-frame status.
// Optional trailing checksum byte is enabled by defining FRAME_CHECKSUM_EN.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int         WORD_W         = 16,
    parameter int         MAX_WORDS      = 64,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [WORD_W-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic              done_o,
    output logic [1:0]        err_o
);

    localparam int BPW  = WORD_W / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(BPW - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            r_state;
    logic [BC_W-1:0]   r_byteCnt;
    logic [7:0]        r_wordLen;
    logic [7:0]        r_wordCnt;
    logic [WORD_W-1:0] r_asm;
    logic [TO_W-1:0]   r_toCnt;
    logic [WORD_W-1:0] r_mData;
    logic              r_mValid;
    logic              r_mLast;
    logic              r_done;
    err_t              r_err;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        r_chk;
`endif

    logic              w_sReady;
    logic              w_byteXfer;
    logic              w_wordXfer;
    logic              w_wordDone;
    logic              w_lastWord;
    logic              w_lenBad;
    logic              w_timeout;
    logic [WORD_W-1:0] w_nextAsm;

    // Input side stalls only while a held word is waiting on downstream.
    assign w_sReady   = !(r_mValid && !m_ready_i);
    assign w_byteXfer = s_valid_i && w_sReady;
    assign w_wordXfer = r_mValid && m_ready_i;
    assign w_wordDone = (r_byteCnt == BYTE_LAST);
    assign w_lastWord = (r_wordCnt == r_wordLen);
    assign w_lenBad   = (s_data_i == 8'd0) || (32'(s_data_i) > MAX_WORDS);
    assign w_nextAsm  = WORD_W'({r_asm, s_data_i});

    // A byte arriving in the expiry cycle wins, and backpressure never counts as idle time.
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state != IDLE) && w_sReady
                        && !w_byteXfer && (r_toCnt == TO_LAST);

    assign s_ready_o  = w_sReady;
    assign m_data_o   = r_mData;
    assign m_valid_o  = r_mValid;
    assign m_last_o   = r_mLast;
    assign done_o     = r_done;
    assign err_o      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_byteCnt <= '0;
            r_wordLen <= '0;
            r_wordCnt <= '0;
            r_asm     <= '0;
            r_toCnt   <= '0;
            r_mData   <= '0;
            r_mValid  <= 1'b0;
            r_mLast   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= ERR_OK;
`ifdef FRAME_CHECKSUM_EN
            r_chk     <= '0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_wordXfer) begin
                r_mValid <= 1'b0;
                r_mLast  <= 1'b0;
            end

            if (r_state == IDLE || w_byteXfer) begin
                r_toCnt <= '0;
            end else if (w_sReady && TIMEOUT_CYCLES != 0) begin
                r_toCnt <= r_toCnt + 1'b1;
            end

`ifndef FRAME_CHECKSUM_EN
            // Without a checksum the frame ends when its last word leaves the output register.
            if (w_wordXfer && r_mLast) begin
                r_done <= 1'b1;
                r_err  <= ERR_OK;
            end
`endif

            if (w_timeout) begin
                r_state   <= IDLE;
                r_byteCnt <= '0;
                r_done    <= 1'b1;
                r_err     <= ERR_TIMEOUT;
            end else if (w_byteXfer) begin
                case (r_state)
                    IDLE: begin
                        if (s_data_i == SYNC_BYTE) begin
                            r_state <= LEN;
                        end
                    end
                    LEN: begin
                        if (w_lenBad) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_err   <= ERR_LEN;
                        end else begin
                            r_state   <= PAYLOAD;
                            r_wordLen <= s_data_i;
                            r_wordCnt <= 8'd1;
                            r_byteCnt <= '0;
`ifdef FRAME_CHECKSUM_EN
                            r_chk     <= s_data_i;
`endif
                        end
                    end
                    PAYLOAD: begin
                        r_asm <= w_nextAsm;
`ifdef FRAME_CHECKSUM_EN
                        r_chk <= r_chk ^ s_data_i;
`endif
                        if (w_wordDone) begin
                            r_byteCnt <= '0;
                            r_mData   <= w_nextAsm;
                            r_mValid  <= 1'b1;
                            r_mLast   <= w_lastWord;
                            if (w_lastWord) begin
`ifdef FRAME_CHECKSUM_EN
                                r_state <= CHK;
`else
                                r_state <= IDLE;
`endif
                            end else begin
                                r_wordCnt <= r_wordCnt + 8'd1;
                            end
                        end else begin
                            r_byteCnt <= r_byteCnt + 1'b1;
                        end
                    end
`ifdef FRAME_CHECKSUM_EN
                    CHK: begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_err   <= (s_data_i == r_chk) ? ERR_OK : ERR_CHK;
                    end
`endif
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: directed frames, expected words/status queued, monitor compares.
module tb_uart_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [15:0] m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i;
    logic        done_o;
    logic [1:0]  err_o;

    uart_frame_decoder #(
        .WORD_W        (16),
        .MAX_WORDS     (64),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data_i (s_data_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .m_data_o (m_data_o),
        .m_valid_o(m_valid_o),
        .m_last_o (m_last_o),
        .m_ready_i(m_ready_i),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          isDone;
        logic [15:0] data;
        logic        last;
        logic [1:0]  err;
        int          atCyc;
    } exp_t;

    exp_t       sbQ[$];
    exp_t       monE;
    logic [7:0] txQ[$];
    int         nCompared   = 0;
    int         nMismatched = 0;
    int         lastXfer;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pushWord(input logic [15:0] data, input logic last);
        exp_t e;
        e.isDone = 1'b0; e.data = data; e.last = last; e.err = 2'd0; e.atCyc = -1;
        sbQ.push_back(e);
    endtask

    task automatic pushDone(input logic [1:0] err, input int atCyc);
        exp_t e;
        e.isDone = 1'b1; e.data = 16'h0; e.last = 1'b0; e.err = err; e.atCyc = atCyc;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] b, output int xferCyc);
        bit sent;
        sent    = 1'b0;
        xferCyc = -1;
        for (int i = 0; i < 1000 && !sent; i++) begin
            @(negedge clk);
            s_data_i  = b;
            s_valid_i = 1'b1;
            #2;
            if (s_ready_o) begin
                @(posedge clk);
                #1;
                xferCyc = cyc;
                sent    = 1'b1;
            end
        end
        if (!sent) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL byte_accept: byte 0x%0h never accepted, required within 1000 cycles", b);
        end
    endtask

    task automatic sendQueued(output int lastCyc);
        int c;
        lastCyc = -1;
        foreach (txQ[i]) begin
            applyStimulus(txQ[i], c);
            lastCyc = c;
        end
        @(negedge clk);
        s_valid_i = 1'b0;
        txQ.delete();
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 400 && sbQ.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checkOutput({name, "_pending"}, sbQ.size(), 0);
        sbQ.delete();
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_s_ready"}, {31'b0, s_ready_o}, 1);
        checkOutput({name, "_m_valid"}, {31'b0, m_valid_o}, 0);
        checkOutput({name, "_m_last"},  {31'b0, m_last_o},  0);
        checkOutput({name, "_m_data"},  {16'b0, m_data_o},  0);
        checkOutput({name, "_done"},    {31'b0, done_o},    0);
        checkOutput({name, "_err"},     {30'b0, err_o},     0);
    endtask

    task automatic queueFrameOne();
        txQ = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef FRAME_CHECKSUM_EN
        txQ.push_back(8'h0A);
`endif
        pushWord(16'h1234, 1'b0);
        pushWord(16'h5678, 1'b1);
        pushDone(2'd0, -1);
    endtask

    // Monitor: every word handshake and every done pulse is matched against the head of the queue.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (m_valid_o && m_ready_i) begin
                if (sbQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h last=%0b, expected no output", m_data_o, m_last_o);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("event_is_word", {31'b0, monE.isDone}, 0);
                    if (!monE.isDone) begin
                        checkOutput("word_data", {16'b0, m_data_o}, {16'b0, monE.data});
                        checkOutput("word_last", {31'b0, m_last_o}, {31'b0, monE.last});
                    end
                end
            end
            if (done_o) begin
                if (sbQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpected_done: got done err=%0d, expected no output", err_o);
                end else begin
                    monE = sbQ.pop_front();
                    checkOutput("event_is_done", {31'b0, monE.isDone}, 1);
                    if (monE.isDone) begin
                        checkOutput("done_err", {30'b0, err_o}, {30'b0, monE.err});
                        if (monE.atCyc >= 0) checkOutput("done_cycle", cyc, monE.atCyc);
                    end
                end
            end
        end
    end

    initial begin
        s_data_i  = 8'h00;
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] test 1: nominal frame with leading junk");
        queueFrameOne();
        txQ.push_front(8'hFF);
        txQ.push_front(8'h00);
        sendQueued(lastXfer);
        waitDrain("t1");

`ifdef FRAME_CHECKSUM_EN
        $display("[TB] test 2: bad checksum");
        pushWord(16'h1234, 1'b0);
        pushWord(16'h5678, 1'b1);
        pushDone(2'd2, -1);
        txQ = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0B};
        sendQueued(lastXfer);
        waitDrain("t2");
`endif

        $display("[TB] test 3: length errors");
        pushDone(2'd1, -1);
        txQ = '{8'hA5, 8'h00};
        sendQueued(lastXfer);
        waitDrain("t3a");
        pushDone(2'd1, -1);
        txQ = '{8'hA5, 8'h41};
        sendQueued(lastXfer);
        waitDrain("t3b");

        $display("[TB] test 4: downstream stall on first word");
        @(negedge clk);
        m_ready_i = 1'b0;
        queueFrameOne();
        fork
            sendQueued(lastXfer);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    #1;
                    seen = m_valid_o;
                end
                checkOutput("t4_word_presented", {31'b0, seen}, 1);
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        #1;
                    end
                    checkOutput("t4_hold_data", {16'b0, m_data_o}, 32'h1234);
                    checkOutput("t4_s_ready_low", {31'b0, s_ready_o}, 0);
                end
                @(negedge clk);
                m_ready_i = 1'b1;
            end
        join
        waitDrain("t4");

        $display("[TB] test 5: inter-byte timeout");
        txQ = '{8'hA5, 8'h02, 8'h12};
        sendQueued(lastXfer);
        pushDone(2'd3, lastXfer + 100);
        waitDrain("t5a");
        queueFrameOne();
        sendQueued(lastXfer);
        waitDrain("t5b");

        $display("[TB] test 6: reset mid-payload");
        pushWord(16'h1234, 1'b0);
        txQ = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56};
        sendQueued(lastXfer);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkReset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        waitDrain("t6a");
        queueFrameOne();
        sendQueued(lastXfer);
        waitDrain("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
